// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared types and constants for the miner control path
package miner_pkg;

    localparam int NONCE_W            = 32;
    localparam int SHA_BLOCK_CYCLES   = 66;
    localparam int BLOCKS_PER_ATTEMPT = 3;
    localparam int DEFAULT_ATTEMPT_CYCLES = SHA_BLOCK_CYCLES * BLOCKS_PER_ATTEMPT;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESTART,
        ST_RUN,
        ST_ADVANCE,
        ST_FOUND,
        ST_EXHAUSTED
    } seq_state_e;

endpackage

// File: rtl/attempt_timer.sv
// rtl/attempt_timer.sv - loadable up-counter with clear and terminal-count flag
module attempt_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    input  logic [W-1:0] terminal,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    assign done = (count == terminal);

endmodule

// File: rtl/nonce_sequencer.sv
// rtl/nonce_sequencer.sv - sweeps a nonce range, one timed miner attempt per nonce
module nonce_sequencer
    import miner_pkg::*;
#(
    parameter int ATTEMPT_CYCLES = DEFAULT_ATTEMPT_CYCLES,
    parameter int RESTART_CYCLES = 2,
    parameter int COUNT_W        = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_first,
    input  logic [NONCE_W-1:0] nonce_last,
    input  logic               hash_success,
    output logic [NONCE_W-1:0] nonce,
    output logic               miner_restart,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [COUNT_W-1:0] attempt_count
);

    localparam int TIMER_MAX = (ATTEMPT_CYCLES > RESTART_CYCLES) ? ATTEMPT_CYCLES : RESTART_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    seq_state_e          state, state_next;
    logic [NONCE_W-1:0]  last_q, last_next;
    logic [NONCE_W-1:0]  nonce_next, found_nonce_next;
    logic [COUNT_W-1:0]  count_next, count_inc;
    logic                found_next, exhausted_next, restart_next, busy_next;
    logic                start_ok, timer_clear, timer_enable, timer_done;
    logic [TIMER_W-1:0]  timer_count, timer_terminal;

    // One timer serves both phases; its terminal value follows the current state.
    assign timer_enable   = (state == ST_RESTART) || (state == ST_RUN);
    assign timer_terminal = (state == ST_RESTART) ? TIMER_W'(RESTART_CYCLES - 1)
                                                  : TIMER_W'(ATTEMPT_CYCLES - 1);

    attempt_timer #(.W(TIMER_W)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (timer_clear),
        .load       (1'b0),
        .load_value ('0),
        .enable     (timer_enable),
        .terminal   (timer_terminal),
        .count      (timer_count),
        .done       (timer_done)
    );

    always_comb begin
        state_next       = state;
        last_next        = last_q;
        nonce_next       = nonce;
        found_next       = found;
        exhausted_next   = exhausted;
        found_nonce_next = found_nonce;
        count_next       = attempt_count;
        timer_clear      = 1'b0;
        count_inc        = (attempt_count == '1) ? attempt_count : attempt_count + COUNT_W'(1);
        start_ok         = start && ((state == ST_IDLE) || (state == ST_FOUND) ||
                                     (state == ST_EXHAUSTED));

        if (abort) begin
            state_next = ST_IDLE;
        end else if (start_ok) begin
            last_next      = nonce_last;
            found_next     = 1'b0;
            exhausted_next = 1'b0;
            count_next     = '0;
            if (nonce_first > nonce_last) begin
                exhausted_next = 1'b1;
                state_next     = ST_EXHAUSTED;
            end else begin
                nonce_next  = nonce_first;
                timer_clear = 1'b1;
                state_next  = ST_RESTART;
            end
        end else begin
            case (state)
                ST_RESTART: begin
                    if (timer_done) begin
                        timer_clear = 1'b1;
                        state_next  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Success wins over a coincident window end.
                    if (hash_success) begin
                        found_next       = 1'b1;
                        found_nonce_next = nonce;
                        count_next       = count_inc;
                        state_next       = ST_FOUND;
                    end else if (timer_done) begin
                        count_next = count_inc;
                        state_next = ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    if (nonce == last_q) begin
                        exhausted_next = 1'b1;
                        state_next     = ST_EXHAUSTED;
                    end else begin
                        nonce_next  = nonce + NONCE_W'(1);
                        timer_clear = 1'b1;
                        state_next  = ST_RESTART;
                    end
                end
                default: ;
            endcase
        end

        restart_next = (state_next == ST_RESTART);
        busy_next    = (state_next == ST_RESTART) || (state_next == ST_RUN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            last_q        <= '0;
            nonce         <= '0;
            found         <= 1'b0;
            exhausted     <= 1'b0;
            found_nonce   <= '0;
            attempt_count <= '0;
            miner_restart <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            last_q        <= last_next;
            nonce         <= nonce_next;
            found         <= found_next;
            exhausted     <= exhausted_next;
            found_nonce   <= found_nonce_next;
            attempt_count <= count_next;
            miner_restart <= restart_next;
            busy          <= busy_next;
        end
    end

endmodule

// File: tb/tb_nonce_sequencer.sv
// tb/tb_nonce_sequencer.sv - directed self-checking bench for nonce_sequencer
module tb_nonce_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] nonce_first;
    logic [31:0] nonce_last;
    logic        hash_success;
    logic [31:0] nonce;
    logic        miner_restart;
    logic        busy;
    logic        found;
    logic        exhausted;
    logic [31:0] found_nonce;
    logic [31:0] attempt_count;

    int checks = 0;
    int errors = 0;

    nonce_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .nonce_first   (nonce_first),
        .nonce_last    (nonce_last),
        .hash_success  (hash_success),
        .nonce         (nonce),
        .miner_restart (miner_restart),
        .busy          (busy),
        .found         (found),
        .exhausted     (exhausted),
        .found_nonce   (found_nonce),
        .attempt_count (attempt_count)
    );

    always #5 clock = ~clock;

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] first, input logic [31:0] last);
        nonce_first = first;
        nonce_last  = last;
        start       = 1'b1;
        cycles(1);
        start       = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; hash_success = 1'b0;
        nonce_first = '0; nonce_last = '0;
        cycles(2);
        chk("rst_nonce", nonce, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_restart", miner_restart, 32'h0);
        chk("rst_count", attempt_count, 32'h0);
        reset = 1'b1;
        cycles(3);
        chk("idle_busy", busy, 32'h0);
        chk("idle_found", found, 32'h0);

        // Single attempt, no success
        pulse_start(32'h42A14695, 32'h42A14695);
        chk("t1_restart_c1", miner_restart, 32'h1);
        chk("t1_nonce", nonce, 32'h42A14695);
        cycles(1);
        chk("t1_restart_c2", miner_restart, 32'h1);
        cycles(1);
        chk("t1_run_restart", miner_restart, 32'h0);
        chk("t1_run_busy", busy, 32'h1);
        cycles(197);
        chk("t1_last_run_busy", busy, 32'h1);
        chk("t1_last_run_count", attempt_count, 32'h0);
        cycles(1);
        chk("t1_adv_count", attempt_count, 32'h1);
        chk("t1_adv_exh", exhausted, 32'h0);
        cycles(1);
        chk("t1_exhausted", exhausted, 32'h1);
        chk("t1_found", found, 32'h0);
        chk("t1_nonce_end", nonce, 32'h42A14695);
        chk("t1_count_end", attempt_count, 32'h1);

        // Success on third nonce, coincident with window end
        pulse_start(32'h100, 32'h1FF);
        chk("t2_exh_cleared", exhausted, 32'h0);
        chk("t2_count_cleared", attempt_count, 32'h0);
        hash_success = 1'b1;
        cycles(1);
        hash_success = 1'b0;
        chk("t2_ignore_in_restart", found, 32'h0);
        cycles(200);
        chk("t2_nonce1", nonce, 32'h101);
        chk("t2_restart1", miner_restart, 32'h1);
        chk("t2_count1", attempt_count, 32'h1);
        cycles(400);
        chk("t2_nonce2", nonce, 32'h102);
        chk("t2_count2", attempt_count, 32'h2);
        chk("t2_busy_run", busy, 32'h1);
        hash_success = 1'b1;
        cycles(1);
        hash_success = 1'b0;
        chk("t2_found", found, 32'h1);
        chk("t2_found_nonce", found_nonce, 32'h102);
        chk("t2_count3", attempt_count, 32'h3);
        chk("t2_busy_done", busy, 32'h0);
        cycles(5);
        chk("t2_no_advance", nonce, 32'h102);
        chk("t2_found_sticky", found, 32'h1);
        chk("t2_exh_clear", exhausted, 32'h0);

        // Top of range, no wrap
        pulse_start(32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("t3_found_cleared", found, 32'h0);
        cycles(201);
        chk("t3_exhausted", exhausted, 32'h1);
        chk("t3_count", attempt_count, 32'h1);
        cycles(3);
        chk("t3_nonce_hold", nonce, 32'hFFFFFFFF);

        // Inverted range
        pulse_start(32'h20, 32'h1F);
        chk("t4_exhausted", exhausted, 32'h1);
        chk("t4_count", attempt_count, 32'h0);
        chk("t4_restart", miner_restart, 32'h0);
        chk("t4_busy", busy, 32'h0);

        // Abort mid-RUN of second nonce, start while busy ignored
        pulse_start(32'h4, 32'h9);
        chk("t5_exh_cleared", exhausted, 32'h0);
        cycles(9);
        nonce_first = 32'h77; nonce_last = 32'h80; start = 1'b1;
        cycles(1);
        start = 1'b0;
        chk("t5_busy_start_ign", busy, 32'h1);
        chk("t5_nonce_start_ign", nonce, 32'h4);
        cycles(243);
        chk("t5_nonce5", nonce, 32'h5);
        chk("t5_run", busy, 32'h1);
        abort = 1'b1; start = 1'b1;
        cycles(1);
        abort = 1'b0; start = 1'b0;
        chk("t5_abort_busy", busy, 32'h0);
        chk("t5_abort_restart", miner_restart, 32'h0);
        chk("t5_abort_count", attempt_count, 32'h1);
        chk("t5_abort_nonce", nonce, 32'h5);
        cycles(3);
        chk("t5_stay_idle", busy, 32'h0);
        pulse_start(32'h30, 32'h30);
        chk("t5_new_restart", miner_restart, 32'h1);
        chk("t5_new_nonce", nonce, 32'h30);
        chk("t5_new_count", attempt_count, 32'h0);
        cycles(201);
        chk("t5_new_exh", exhausted, 32'h1);
        chk("t5_new_count1", attempt_count, 32'h1);

        // Asynchronous reset mid-RUN
        pulse_start(32'h10, 32'h20);
        cycles(5);
        chk("t6_pre_busy", busy, 32'h1);
        reset = 1'b0;
        #1;
        chk("t6_rst_nonce", nonce, 32'h0);
        chk("t6_rst_busy", busy, 32'h0);
        chk("t6_rst_exh", exhausted, 32'h0);
        chk("t6_rst_count", attempt_count, 32'h0);
        cycles(1);
        reset = 1'b1;
        cycles(3);
        chk("t6_idle_busy", busy, 32'h0);
        chk("t6_idle_restart", miner_restart, 32'h0);
        chk("t6_idle_nonce", nonce, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
